// File: rtl/mdu_stall_ctrl.sv
// Multiply/divide busy sequencer and F/D freeze / E bubble stall generator.
// Optional stall statistics counters: define MDU_STALL_STATS_EN.
module mdu_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        E_start,
    input  logic        E_is_div,
    input  logic        D_md_use,
    input  logic        hazard_stall_in,
`ifdef MDU_STALL_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] md_stall_cycles,
`endif
    output logic        busy,
    output logic        stall,
    output logic        md_done,
    output logic        md_start_eff
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             is_idle;
    logic             last_cnt;
    logic             md_term;

    assign is_idle      = (state_q == IDLE);
    assign last_cnt     = (cnt_q == CNT_ONE);
    assign busy         = ~is_idle;
    assign md_done      = busy & last_cnt;
    assign md_start_eff = E_start & ~Req & is_idle;

    // The mult/div sitting in E already blocks a HI/LO user in D.
    assign md_term = D_md_use & (md_start_eff | busy);
    assign stall   = ~Req & (hazard_stall_in | md_term);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (md_start_eff) begin
                    state_d = E_is_div ? DIV : MULT;
                    cnt_d   = E_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            MULT, DIV: begin
                if (last_cnt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MDU_STALL_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] md_stall_cycles_q;
    logic [31:0] md_stall_cycles_d;
    logic        md_only;

    // Cycles where only the MDU interlock holds the pipe.
    assign md_only = stall & ~hazard_stall_in;

    always_comb begin
        stall_cycles_d    = stall_cycles_q;
        md_stall_cycles_d = md_stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (md_only && (md_stall_cycles_q != 32'hFFFF_FFFF)) begin
            md_stall_cycles_d = md_stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q    <= '0;
            md_stall_cycles_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            md_stall_cycles_q <= md_stall_cycles_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule
